nokta_carpim_birimi: RTL and testbench
======================================

// Module: nokta_carpim_birimi
// PURPOSE
//  Parametrised multi-cycle dot-product (MAC) unit for the X-extension AI instructions in the execute stage.
//  Buffers a weight vector W and a data vector X, each up to DEPTH elements. On run, sequentially computes
//  sum(W[i]*X[i]) over the loaded length, LANES products per cycle. Returns the result through a
//  busy/result_valid handshake.
// PARAMETERS
//  DATA_W  32  element, product and accumulator width (bits)
//  DEPTH   16  buffer entries per vector; power of two, >=2
//  LANES   1   MACs per cycle; divides DEPTH
//  PTR_W   $clog2(DEPTH)+1  pointer width (derived, localparam)
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset: synchronous, active-high
//  src_reg1_val  in   DATA_W  rs1 operand (first element to load)
//  src_reg2_val  in   DATA_W  rs2 operand (second element when rs2_enable)
//  load_w        in   1       push operand(s) into W
//  load_x        in   1       push operand(s) into X
//  clr_w         in   1       empty W (pointer to 0)
//  clr_x         in   1       empty X (pointer to 0)
//  rs2_enable    in   1       load pushes 2 elements (rs1 then rs2) instead of 1
//  signed_mode   in   1       operands signed; sampled on accepted run
//  run           in   1       start dot product
//  busy          out  1       computation in progress
//  result_valid  out  1       1-cycle pulse: dst_reg_val updated
//  dst_reg_val   out  DATA_W  last result; held until next result_valid
//  w_full,x_full out  1       pointer == DEPTH (combinational from pointer)
//  w_empty,x_empty out 1      pointer == 0 (combinational from pointer)
//  exception     out  1       1-cycle pulse: illegal operation (see below)
// BEHAVIOUR
//  - Reset: w_ptr=x_ptr=0, FSM=IDLE, busy=0, result_valid=0, dst_reg_val=0, exception=0,
//    w_empty=x_empty=1, w_full=x_full=0. Buffer contents need not be reset; entries >= ptr are never read.
//  - Load (IDLE only): element rs1 written at ptr; if rs2_enable, rs2 written at ptr+1; ptr += 1 or 2.
//    - Overflow (ptr+n > DEPTH): elements that fit are written, ptr saturates at DEPTH, exception pulses next cycle.
//  - clr_* same cycle as load_* on the same vector: clear wins, load dropped, no exception.
//    W and X operations are independent and may coincide.
//  - load/clr while busy: ignored, exception pulses. run while busy: ignored, no exception.
//  - run in IDLE:
//    - If w_ptr != x_ptr: no computation, exception next cycle, no result_valid.
//    - Else N=w_ptr: FSM IDLE->CALC; acc=0; idx=0; busy=1 from next cycle.
//  - CALC: each cycle acc += sum of W[idx+k]*X[idx+k], k<LANES, lanes with idx+k>=N contribute 0; idx += LANES.
//    - After last group FSM->DONE.
//    - DONE: dst_reg_val<=acc, result_valid=1, busy=0, FSM->IDLE.
//    - Latency run->result_valid = ceil(N/LANES)+1 cycles; N=0 gives result 0 after 1 cycle (CALC skipped).
//  - Arithmetic: products and sum truncated to low DATA_W bits (mod 2^DATA_W); signed_mode irrelevant unless saturation.
//  - Buffers and pointers unchanged by run; repeated run reuses loaded vectors.
//  - rst mid-CALC: immediate abort, all reset values, no result_valid.
// CONFIGURATION
//  NCB_SATURATE_EN defined:
//    - Products and accumulator computed at 2*DATA_W+$clog2(DEPTH) bits.
//    - Final result clamped to DATA_W range: signed [-2^(W-1), 2^(W-1)-1] or unsigned [0, 2^W-1] per signed_mode.
//    - Clamp adds no latency.
//  Undefined: modulo-2^DATA_W wraparound as above; no wide accumulator logic.
// TESTING (DATA_W=32, DEPTH=16)
//  1. LANES=1: load_w 1..4 (rs2_enable pairs), load_x 5..8, run -> busy 4 cyc, result_valid at +5, dst=70.
//  2. LANES=4: 16 pairs W=i+1, X=2; run -> result_valid at cycle +5, dst=272; w_full=x_full=1.
//  3. w_ptr=3, x_ptr=2, run -> exception pulse next cycle, no result_valid, busy stays 0.
//  4. ptr=15, load_w with rs2_enable -> one write, w_ptr=16, exception pulse; clr_w+load_w same cycle -> w_ptr=0, w_empty=1.
//  5. rst asserted mid-CALC -> next cycle busy=0, dst=0, ptrs 0, no result_valid; empty run -> dst=0 after 1 cycle.
//  6. NCB_SATURATE_EN, signed: W=X=0x7FFFFFFF x2 -> dst=0x7FFFFFFF; without macro -> dst=0x00000002.

Source files
------------

// File: rtl/nokta_carpim_birimi.sv
// Multi-cycle dot-product unit: buffers W and X vectors, then accumulates sum(W[i]*X[i]) LANES per cycle.
// Build option NCB_SATURATE_EN: wide accumulation with the final result clamped to the DATA_W range.
module nokta_carpim_birimi #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] src_reg1_val,
  input  logic [DATA_W-1:0] src_reg2_val,
  input  logic              load_w,
  input  logic              load_x,
  input  logic              clr_w,
  input  logic              clr_x,
  input  logic              rs2_enable,
  input  logic              signed_mode,
  input  logic              run,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] dst_reg_val,
  output logic              w_full,
  output logic              x_full,
  output logic              w_empty,
  output logic              x_empty,
  output logic              exception,
  output logic [1:0]        dbg_state
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(DEPTH) + 1;
`ifdef NCB_SATURATE_EN
  localparam int ACC_W = 2 * DATA_W + $clog2(DEPTH);
  localparam logic [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LANES_P = PTR_W'(LANES);
  localparam logic [PTR_W:0]   DEPTH_S = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  w_ptr_q, w_ptr_d, x_ptr_q, x_ptr_d;
  logic [PTR_W-1:0]  idx_q, idx_d, n_q, n_d;
  logic [ACC_W-1:0]  acc_q, acc_d, lane_sum;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic              signed_q, signed_d, exc_q, exc_d;
  logic [DATA_W-1:0] w_mem_q [DEPTH];
  logic [DATA_W-1:0] x_mem_q [DEPTH];
  logic [PTR_W:0]    w_sum, x_sum;
  logic [PTR_W-1:0]  w_p1, x_p1, lane_i;
  logic              can_load, start, last_grp;

`ifdef NCB_SATURATE_EN
  function automatic logic [ACC_W-1:0] widen(input logic [DATA_W-1:0] v, input logic sgn);
    return sgn ? {{(ACC_W-DATA_W){v[DATA_W-1]}}, v} : {{(ACC_W-DATA_W){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] clamp(input logic [ACC_W-1:0] v, input logic sgn);
    logic [DATA_W-1:0] r;
    r = v[DATA_W-1:0];
    if (sgn) begin
      if ($signed(v) > $signed(SMAX))      r = {1'b0, {(DATA_W-1){1'b1}}};
      else if ($signed(v) < $signed(SMIN)) r = {1'b1, {(DATA_W-1){1'b0}}};
    end else if (|v[ACC_W-1:DATA_W]) begin
      r = '1;
    end
    return r;
  endfunction
`else
  logic unused_signed;
  assign unused_signed = signed_q;
`endif

  // Loads and clears are only blocked while products are being accumulated.
  assign can_load = (state_q != ST_CALC);
  assign start    = (state_q == ST_IDLE) && run && (w_ptr_q == x_ptr_q);
  assign last_grp = (idx_q + LANES_P) >= n_q;
  assign w_sum    = {1'b0, w_ptr_q} + (rs2_enable ? (PTR_W+1)'(2) : (PTR_W+1)'(1));
  assign x_sum    = {1'b0, x_ptr_q} + (rs2_enable ? (PTR_W+1)'(2) : (PTR_W+1)'(1));
  assign w_p1     = w_ptr_q + PTR_W'(1);
  assign x_p1     = x_ptr_q + PTR_W'(1);

  always_comb begin
    w_ptr_d = w_ptr_q;
    x_ptr_d = x_ptr_q;
    exc_d   = 1'b0;
    if (can_load) begin
      if (clr_w) w_ptr_d = '0;
      else if (load_w) begin
        if (w_sum > DEPTH_S) begin
          w_ptr_d = DEPTH_P;
          exc_d   = 1'b1;
        end else w_ptr_d = w_sum[PTR_W-1:0];
      end
      if (clr_x) x_ptr_d = '0;
      else if (load_x) begin
        if (x_sum > DEPTH_S) begin
          x_ptr_d = DEPTH_P;
          exc_d   = 1'b1;
        end else x_ptr_d = x_sum[PTR_W-1:0];
      end
      if ((state_q == ST_IDLE) && run && (w_ptr_q != x_ptr_q)) exc_d = 1'b1;
    end else if (load_w || load_x || clr_w || clr_x) begin
      exc_d = 1'b1;
    end
  end

  // Overflowing writes are dropped element by element; only slots below DEPTH are touched.
  always_ff @(posedge clk) begin
    if (!rst && can_load && load_w && !clr_w) begin
      if (w_ptr_q < DEPTH_P) w_mem_q[w_ptr_q[IDX_W-1:0]] <= src_reg1_val;
      if (rs2_enable && (w_p1 < DEPTH_P)) w_mem_q[w_p1[IDX_W-1:0]] <= src_reg2_val;
    end
    if (!rst && can_load && load_x && !clr_x) begin
      if (x_ptr_q < DEPTH_P) x_mem_q[x_ptr_q[IDX_W-1:0]] <= src_reg1_val;
      if (rs2_enable && (x_p1 < DEPTH_P)) x_mem_q[x_p1[IDX_W-1:0]] <= src_reg2_val;
    end
  end

  always_comb begin
    lane_sum = '0;
    lane_i   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_i = idx_q + PTR_W'(k);
      if (lane_i < n_q) begin
`ifdef NCB_SATURATE_EN
        lane_sum = lane_sum + widen(w_mem_q[lane_i[IDX_W-1:0]], signed_q)
                            * widen(x_mem_q[lane_i[IDX_W-1:0]], signed_q);
`else
        lane_sum = lane_sum + w_mem_q[lane_i[IDX_W-1:0]] * x_mem_q[lane_i[IDX_W-1:0]];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (w_ptr_q == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_grp) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == ST_CALC);
    result_valid = (state_q == ST_DONE);
  end

  // The result register is written on the last accumulate cycle so it is valid alongside result_valid.
  always_comb begin
    acc_d    = acc_q;
    idx_d    = idx_q;
    n_d      = n_q;
    signed_d = signed_q;
    dst_d    = dst_q;
    if (start) begin
      acc_d    = '0;
      idx_d    = '0;
      n_d      = w_ptr_q;
      signed_d = signed_mode;
      if (w_ptr_q == '0) dst_d = '0;
    end else if (state_q == ST_CALC) begin
      acc_d = acc_q + lane_sum;
      idx_d = idx_q + LANES_P;
`ifdef NCB_SATURATE_EN
      if (last_grp) dst_d = clamp(acc_d, signed_q);
`else
      if (last_grp) dst_d = acc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q  <= '0;
      x_ptr_q  <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      dst_q    <= '0;
      signed_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      w_ptr_q  <= w_ptr_d;
      x_ptr_q  <= x_ptr_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      dst_q    <= dst_d;
      signed_q <= signed_d;
      exc_q    <= exc_d;
    end
  end

  assign dst_reg_val = dst_q;
  assign exception   = exc_q;
  assign w_full      = (w_ptr_q == DEPTH_P);
  assign x_full      = (x_ptr_q == DEPTH_P);
  assign w_empty     = (w_ptr_q == '0);
  assign x_empty     = (x_ptr_q == '0);
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_nokta_carpim_birimi.sv
// Randomized scoreboard bench for nokta_carpim_birimi: queue-based vector model, result/latency monitor.
module tb_nokta_carpim_birimi;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LANES  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] src_reg1_val, src_reg2_val, dst_reg_val;
  logic              load_w, load_x, clr_w, clr_x, rs2_enable, signed_mode, run;
  logic              busy, result_valid, w_full, x_full, w_empty, x_empty, exception;
  logic [1:0]        dbg_state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] mw[$];
  logic [DATA_W-1:0] mx[$];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];

  nokta_carpim_birimi #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .src_reg1_val(src_reg1_val), .src_reg2_val(src_reg2_val),
    .load_w(load_w), .load_x(load_x), .clr_w(clr_w), .clr_x(clr_x), .rs2_enable(rs2_enable),
    .signed_mode(signed_mode), .run(run), .busy(busy), .result_valid(result_valid),
    .dst_reg_val(dst_reg_val), .w_full(w_full), .x_full(x_full), .w_empty(w_empty),
    .x_empty(x_empty), .exception(exception), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: exact dot product in wide signed arithmetic, then wrap or clamp.
  function automatic logic [DATA_W-1:0] ref_dot(input bit sgn);
    logic signed [127:0] s, a, b;
    s = '0;
    foreach (mw[i]) begin
      if (sgn) begin
        a = $signed(mw[i]);
        b = $signed(mx[i]);
      end else begin
        a = {96'd0, mw[i]};
        b = {96'd0, mx[i]};
      end
      s = s + a * b;
    end
`ifdef NCB_SATURATE_EN
    if (sgn) begin
      if (s > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
      if (s < -128'sh80000000) return 32'h80000000;
    end else if (s > 128'shFFFFFFFF) begin
      return 32'hFFFFFFFF;
    end
`endif
    return s[31:0];
  endfunction

  function automatic logic [DATA_W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin : monitor
    logic [DATA_W-1:0] e;
    int ec;
    if (!rst && result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=no_result (cycle %0d)", dst_reg_val, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", 64'(dst_reg_val), 64'(e));
        check("latency", 64'(cyc), 64'(ec));
      end
    end
  end

  // Driver: one load/clear operation on either or both vectors, exception checked next cycle.
  task automatic op(input bit lw, input bit lx, input bit cw, input bit cx, input bit two,
                    input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit during_busy);
    bit exc_e;
    exc_e = 1'b0;
    @(negedge clk);
    load_w = lw; load_x = lx; clr_w = cw; clr_x = cx; rs2_enable = two;
    src_reg1_val = a; src_reg2_val = b;
    if (during_busy) begin
      exc_e = lw | lx | cw | cx;
    end else begin
      if (cw) mw.delete();
      else if (lw) begin
        if (mw.size() + (two ? 2 : 1) > DEPTH) exc_e = 1'b1;
        if (mw.size() < DEPTH) mw.push_back(a);
        if (two && mw.size() < DEPTH) mw.push_back(b);
      end
      if (cx) mx.delete();
      else if (lx) begin
        if (mx.size() + (two ? 2 : 1) > DEPTH) exc_e = 1'b1;
        if (mx.size() < DEPTH) mx.push_back(a);
        if (two && mx.size() < DEPTH) mx.push_back(b);
      end
    end
    @(negedge clk);
    load_w = 0; load_x = 0; clr_w = 0; clr_x = 0; rs2_enable = 0;
    check("load_exception", 64'(exception), 64'(exc_e));
    check("w_empty", 64'(w_empty), 64'(mw.size() == 0));
    check("x_full", 64'(x_full), 64'(mx.size() == DEPTH));
    check("w_full", 64'(w_full), 64'(mw.size() == DEPTH));
    check("x_empty", 64'(x_empty), 64'(mx.size() == 0));
  endtask

  task automatic run_op(input bit sgn);
    bit ok;
    int n;
    @(negedge clk);
    run = 1'b1;
    signed_mode = sgn;
    ok = (mw.size() == mx.size());
    n  = mw.size();
    if (ok) begin
      exp_q.push_back(ref_dot(sgn));
      exp_cyc_q.push_back(cyc + (n + LANES - 1) / LANES + 1);
    end
    @(negedge clk);
    run = 1'b0;
    signed_mode = 1'($urandom_range(0, 1));
    check("run_exception", 64'(exception), 64'(!ok));
    check("busy_after_run", 64'(busy), 64'(ok && n > 0));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_state();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_result_valid", 64'(result_valid), 64'(0));
    check("rst_dst", 64'(dst_reg_val), 64'(0));
    check("rst_exception", 64'(exception), 64'(0));
    check("rst_w_empty", 64'(w_empty), 64'(1));
    check("rst_x_empty", 64'(x_empty), 64'(1));
    check("rst_w_full", 64'(w_full), 64'(0));
    check("rst_x_full", 64'(x_full), 64'(0));
  endtask

  task automatic fill(input int nw, input int nx);
    bit two;
    while (mw.size() < nw) begin
      two = ($urandom_range(0, 1) == 1) && (nw - mw.size() >= 2);
      op(1, 0, 0, 0, two, rand_val(), rand_val(), 0);
    end
    while (mx.size() < nx) begin
      two = ($urandom_range(0, 1) == 1) && (nx - mx.size() >= 2);
      op(0, 1, 0, 0, two, rand_val(), rand_val(), 0);
    end
  endtask

  initial begin
    int nw, nx;
    src_reg1_val = '0; src_reg2_val = '0;
    load_w = 0; load_x = 0; clr_w = 0; clr_x = 0; rs2_enable = 0; signed_mode = 0; run = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    // Pairs W={1,2,3,4}, X={5,6,7,8}: 70
    op(1, 0, 0, 0, 1, 32'd1, 32'd2, 0);
    op(1, 0, 0, 0, 1, 32'd3, 32'd4, 0);
    op(0, 1, 0, 0, 1, 32'd5, 32'd6, 0);
    op(0, 1, 0, 0, 1, 32'd7, 32'd8, 0);
    run_op(0);
    wait_done();

    // Full buffers W=i+1, X=2: 272; load/clear while busy are rejected
    op(0, 0, 1, 1, 0, '0, '0, 0);
    for (int i = 0; i < 8; i++) op(1, 0, 0, 0, 1, 32'(2 * i + 1), 32'(2 * i + 2), 0);
    for (int i = 0; i < 8; i++) op(0, 1, 0, 0, 1, 32'd2, 32'd2, 0);
    run_op(0);
    op(1, 0, 0, 1, 0, 32'h55, '0, 1);
    wait_done();
    run_op(1);
    wait_done();

    // Length mismatch 3 vs 2
    op(0, 0, 1, 1, 0, '0, '0, 0);
    op(1, 0, 0, 0, 1, 32'd9, 32'd9, 0);
    op(1, 0, 0, 0, 0, 32'd9, 32'd9, 0);
    op(0, 1, 0, 0, 1, 32'd9, 32'd9, 0);
    run_op(0);
    wait_done();

    // Overflow at 15 with a pair, then clear beats load
    op(0, 0, 1, 1, 0, '0, '0, 0);
    for (int i = 0; i < 15; i++) op(1, 0, 0, 0, 0, 32'(i), '0, 0);
    op(1, 0, 0, 0, 1, 32'hAA, 32'hBB, 0);
    op(1, 0, 1, 0, 1, 32'hCC, 32'hDD, 0);

    // Large signed operands: clamps or wraps depending on build
    op(0, 0, 1, 1, 0, '0, '0, 0);
    op(1, 1, 0, 0, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
    run_op(1);
    wait_done();

    for (int it = 0; it < 30; it++) begin
      op(0, 0, 1, 1, 0, '0, '0, 0);
      nw = $urandom_range(0, DEPTH);
      nx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DEPTH)) : nw;
      fill(nw, nx);
      run_op(1'($urandom_range(0, 1)));
      wait_done();
      if ($urandom_range(0, 2) == 0) begin
        run_op(1'($urandom_range(0, 1)));
        wait_done();
      end
    end

    // Reset in the middle of a computation, then an empty run
    op(0, 0, 1, 1, 0, '0, '0, 0);
    for (int i = 0; i < 8; i++) op(1, 1, 0, 0, 1, rand_val(), rand_val(), 0);
    run_op(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    mw.delete();
    mx.delete();
    check_reset_state();
    repeat (8) @(negedge clk);
    run_op(0);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
